// File: rtl/reg_scoreboard.sv
// Write-side hazard tracker: counts in-flight writes per register and refuses conflicting issues.
// Latency: stall is combinational; counts, busy_mask and pending_total update at the next posedge.
// Backpressure: stall is raised on a RAW hit or a saturated rd counter; retire is never refused.
module reg_scoreboard #(
    parameter int MAX_PENDING = 3,
    parameter int CW          = $clog2(MAX_PENDING + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic        issue_rs1_used,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs2_used,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_w,
    output logic        stall,
    input  logic        retire_valid,
    input  logic [4:0]  retire_rd,
    input  logic        flush,
    output logic [31:0] busy_mask,
    output logic [7:0]  pending_total,
    output logic        underflow_err
);

    logic [CW-1:0] cnt     [32];
    logic [CW-1:0] cnt_nxt [32];
    logic          raw_hit;
    logic          full_hit;
    logic          accept;
    logic          inc_go;
    logic          ret_go;
    logic          same_reg;
    logic          ret_dec;
    logic          uf_set;
    logic [7:0]    total_nxt;

    assign raw_hit  = (issue_rs1_used && issue_rs1 != 5'd0 && cnt[issue_rs1] != '0) ||
                      (issue_rs2_used && issue_rs2 != 5'd0 && cnt[issue_rs2] != '0);
    assign full_hit = issue_rd_w && issue_rd != 5'd0 && cnt[issue_rd] == CW'(MAX_PENDING);
    assign stall    = issue_valid && (raw_hit || full_hit);

    assign accept   = issue_valid && !stall && !flush;
    assign inc_go   = accept && issue_rd_w && issue_rd != 5'd0;
    assign ret_go   = retire_valid && retire_rd != 5'd0 && !flush;
    // A matching accept and retire cancel out, even on a zero count.
    assign same_reg = inc_go && ret_go && issue_rd == retire_rd;
    assign ret_dec  = ret_go && !same_reg && cnt[retire_rd] != '0;
    assign uf_set   = ret_go && !same_reg && cnt[retire_rd] == '0;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_nxt[r] = cnt[r];
            if (r == 0 || flush) begin
                cnt_nxt[r] = '0;
            end else if (!same_reg) begin
                if (inc_go && issue_rd == 5'(r))
                    cnt_nxt[r] = cnt[r] + CW'(1);
                else if (ret_dec && retire_rd == 5'(r))
                    cnt_nxt[r] = cnt[r] - CW'(1);
            end
        end
    end

    always_comb begin
        total_nxt = pending_total;
        if (flush)
            total_nxt = 8'd0;
        else if (!same_reg)
            total_nxt = pending_total + 8'(inc_go) - 8'(ret_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= '0;
            pending_total <= 8'd0;
            underflow_err <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= cnt_nxt[r];
            pending_total <= total_nxt;
            if (uf_set)
                underflow_err <= 1'b1;
        end
    end

    always_comb begin
        busy_mask = 32'd0;
        for (int r = 1; r < 32; r++)
            busy_mask[r] = (cnt[r] != '0);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized bench for reg_scoreboard against a per-register count model.
module tb_reg_scoreboard;

    localparam int MAXP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic        issue_rs1_used;
    logic [4:0]  issue_rs2;
    logic        issue_rs2_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_w;
    logic        stall;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic [7:0]  pending_total;
    logic        underflow_err;

    int nvec = 0;
    int nerr = 0;

    int m_cnt [32];
    bit m_uf;

    reg_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_w(issue_rd_w), .stall(stall),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
        .busy_mask(busy_mask), .pending_total(pending_total), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_mask();
        logic [31:0] m = 32'd0;
        for (int r = 1; r < 32; r++) m[r] = (m_cnt[r] > 0);
        return m;
    endfunction

    function automatic logic [7:0] m_total();
        int s = 0;
        for (int r = 1; r < 32; r++) s += m_cnt[r];
        return 8'(s);
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    task automatic check_state(input string tag);
        nvec++;
        assert (busy_mask === m_mask()) else begin
            nerr++; $error("FAIL %s busy_mask got %h exp %h", tag, busy_mask, m_mask());
        end
        nvec++;
        assert (pending_total === m_total()) else begin
            nerr++; $error("FAIL %s pending_total got %0d exp %0d", tag, pending_total, m_total());
        end
        nvec++;
        assert (underflow_err === m_uf) else begin
            nerr++; $error("FAIL %s underflow_err got %b exp %b", tag, underflow_err, m_uf);
        end
    endtask

    // One cycle: drive, check stall before the edge, advance model, check state after it.
    task automatic step(input string tag,
                        input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit w, input bit rv, input int rrd, input bit fl);
        bit exp_stall, do_inc, do_ret;
        issue_valid = v; issue_rs1 = 5'(rs1); issue_rs1_used = u1;
        issue_rs2 = 5'(rs2); issue_rs2_used = u2; issue_rd = 5'(rd); issue_rd_w = w;
        retire_valid = rv; retire_rd = 5'(rrd); flush = fl;
        exp_stall = v && ((u1 && rs1 != 0 && m_cnt[rs1] > 0) ||
                          (u2 && rs2 != 0 && m_cnt[rs2] > 0) ||
                          (w && rd != 0 && m_cnt[rd] == MAXP));
        #1;
        nvec++;
        assert (stall === exp_stall) else begin
            nerr++; $error("FAIL %s stall got %b exp %b", tag, stall, exp_stall);
        end
        @(posedge clk);
        if (fl) begin
            m_clear();
        end else begin
            do_inc = v && !exp_stall && w && rd != 0;
            do_ret = rv && rrd != 0;
            if (!(do_inc && do_ret && rd == rrd)) begin
                if (do_inc) m_cnt[rd]++;
                if (do_ret) begin
                    if (m_cnt[rrd] > 0) m_cnt[rrd]--;
                    else m_uf = 1'b1;
                end
            end
        end
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_clear(); m_uf = 1'b0;
        rst_n = 1'b0;
        issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_rd_w = 0; retire_valid = 0; retire_rd = 0; flush = 0;
        #12;
        nvec++;
        assert (stall === 1'b0) else begin nerr++; $error("FAIL reset stall got %b exp 0", stall); end
        check_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle("idle");

        // RAW on x5
        step("raw_issue", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step("raw_stall", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        step("raw_retire", 1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        step("raw_go", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);

        // Capacity on x7
        for (int i = 0; i < 3; i++) step("cap_fill", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("cap_full", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("cap_retire", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        step("cap_refill", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);

        // Simultaneous events on x9
        step("x9_issue", 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step("x9_both", 1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        step("x9_ret", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step("x9_zero_both", 1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        step("x9_ret2", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step("x9_uf", 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step("uf_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // x0 ignored everywhere
        step("x0", 1, 0, 1, 0, 1, 0, 1, 1, 0, 0);

        // Flush beats a concurrent issue
        step("fl_a", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step("fl_b", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step("fl_c", 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        step("fl_go", 1, 0, 0, 0, 0, 3, 1, 1, 4, 1);

        // Randomized traffic concentrated on a few registers
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(3, 0) != 0,
                 int'($urandom_range(7, 0)), $urandom_range(2, 0) == 0,
                 int'($urandom_range(7, 0)), $urandom_range(3, 0) == 0,
                 int'($urandom_range(7, 0)), $urandom_range(4, 0) != 0,
                 $urandom_range(2, 0) != 0, int'($urandom_range(7, 0)),
                 $urandom_range(40, 0) == 0);
            if (i == 300) begin
                // Mid-cycle asynchronous reset with pending state
                for (int k = 0; k < 4; k++) step("prefill", 1, 0, 0, 0, 0, k + 1, 1, 0, 0, 0);
                issue_valid = 1; issue_rs1 = 5'd1; issue_rs1_used = 1; issue_rd_w = 0;
                retire_valid = 0; flush = 0;
                rst_n = 1'b0;
                m_clear(); m_uf = 1'b0;
                #1;
                nvec++;
                assert (stall === 1'b0) else begin nerr++; $error("FAIL async_rst stall got %b exp 0", stall); end
                check_state("async_rst");
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
